aon_lfclk_rtc: RTL

- Real-time counter for the AON block. It consumes the 32.768 kHz divided clock (lfclk_in), which the clock divider produces as a register in the clk domain.
- Samples lfclk_in in the clk domain and counts its rising edges in a 48-bit counter.
- Exposes a scaled 32-bit view of the counter, a compare register and a level interrupt.
- Software accesses it through a simple single-cycle register port from the AON bus bridge.

---
 rtl/aon_rtc_pkg.sv | 20 ++
 rtl/lfclk_edge_det.sv | 19 +
 rtl/aon_lfclk_rtc.sv | 109 ++++++++++
 3 files changed

// File: rtl/aon_rtc_pkg.sv
// Shared constants for the AON real-time counter: register indices, CFG field
// positions and reset values.
package aon_rtc_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RTC_CFG      = 3'd0;
  localparam logic [ADDR_W-1:0] RTC_COUNT_LO = 3'd1;
  localparam logic [ADDR_W-1:0] RTC_COUNT_HI = 3'd2;
  localparam logic [ADDR_W-1:0] RTC_SCALED   = 3'd3;
  localparam logic [ADDR_W-1:0] RTC_CMP      = 3'd4;
  localparam logic [ADDR_W-1:0] RTC_STATUS   = 3'd5;

  localparam int unsigned CFG_EN_BIT    = 0;
  localparam int unsigned CFG_SCALE_LSB = 4;

  localparam logic [DATA_W-1:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/lfclk_edge_det.sv
// Rising-edge detector for the clk-synchronous divided low-frequency clock.
// Produces a one-cycle tick per lfclk period; shared with the AON watchdog.
module lfclk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic lfclk_in,
  output logic tick
);

  logic lf_q;

  always_ff @(posedge clk) begin
    if (reset) lf_q <= 1'b0;
    else       lf_q <= lfclk_in;
  end

  assign tick = lfclk_in & ~lf_q;

endmodule

// File: rtl/aon_lfclk_rtc.sv
// AON real-time counter: counts lfclk rising edges, exposes a scaled view,
// a compare register and a level interrupt through a single-cycle register port.
module aon_lfclk_rtc
  import aon_rtc_pkg::*;
#(
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned CMP_W   = 32,
  parameter int unsigned SCALE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lfclk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              irq
);

  localparam int unsigned HI_W = CNT_W - 32;

  logic               tick;
  logic               en_q;
  logic [SCALE_W-1:0] scale_q;
  logic [CNT_W-1:0]   count_q;
  logic [CMP_W-1:0]   cmp_q;
  logic               ip_q;

  logic [CNT_W-1:0]   shifted_c;
  logic [CMP_W-1:0]   scaled_c;
  logic [DATA_W-1:0]  rd_mux_c;
  logic               wr_cfg_c, wr_lo_c, wr_hi_c, wr_cmp_c;

  lfclk_edge_det u_edge_det (
    .clk      (clk),
    .reset    (reset),
    .lfclk_in (lfclk_in),
    .tick     (tick)
  );

  assign wr_cfg_c = wr_en && (wr_addr == RTC_CFG);
  assign wr_lo_c  = wr_en && (wr_addr == RTC_COUNT_LO);
  assign wr_hi_c  = wr_en && (wr_addr == RTC_COUNT_HI);
  assign wr_cmp_c = wr_en && (wr_addr == RTC_CMP);

  assign shifted_c = count_q >> scale_q;
  assign scaled_c  = shifted_c[CMP_W-1:0];

  // Config and compare registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      scale_q <= '0;
      cmp_q   <= CMP_W'(CMP_RST);
    end else begin
      if (wr_cfg_c) begin
        en_q    <= wr_data[CFG_EN_BIT];
        scale_q <= wr_data[CFG_SCALE_LSB +: SCALE_W];
      end
      if (wr_cmp_c) cmp_q <= CMP_W'(wr_data);
    end
  end

  // Software writes take priority over, and swallow, a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (wr_lo_c) begin
      count_q[31:0] <= wr_data;
    end else if (wr_hi_c) begin
      count_q[CNT_W-1:32] <= wr_data[HI_W-1:0];
    end else if (en_q && tick) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Compare is evaluated every cycle, independent of en
  always_ff @(posedge clk) begin
    if (reset) ip_q <= 1'b0;
    else       ip_q <= (scaled_c >= cmp_q);
  end

  assign irq = ip_q;

  always_comb begin
    rd_mux_c = '0;
    case (rd_addr)
      RTC_CFG: begin
        rd_mux_c[CFG_EN_BIT]               = en_q;
        rd_mux_c[CFG_SCALE_LSB +: SCALE_W] = scale_q;
      end
      RTC_COUNT_LO: rd_mux_c    = count_q[31:0];
      RTC_COUNT_HI: rd_mux_c    = DATA_W'(count_q[CNT_W-1:32]);
      RTC_SCALED:   rd_mux_c    = DATA_W'(scaled_c);
      RTC_CMP:      rd_mux_c    = DATA_W'(cmp_q);
      RTC_STATUS:   rd_mux_c[0] = ip_q;
      default:      rd_mux_c    = '0;
    endcase
  end

  // Read data captures pre-write state and holds until the next read
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux_c;
  end

endmodule
